// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU
// load/store port and the DMA/loader port.
package dmem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int CNT_W      = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, DMA and RAM side signals around the data-memory arbiter.
// The slave view is the arbiter itself; the master view is its surroundings.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_last;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;

  logic              ram_ena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output dma_gnt, dma_rdata,
    output ram_ena, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  dma_gnt, dma_rdata,
    input  ram_ena, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// 8-bit counter that clears on request and otherwise counts up, sticking
// at its maximum instead of wrapping.
module arb_sat_counter
  import dmem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: CPU passes through with zero latency while idle,
// DMA gets registered grants with bounded bursts and a starvation guard.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk_in,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             burst_clr;
  logic             burst_inc;
  logic             wait_clr;
  logic             wait_inc;
  logic             starved;

  arb_sat_counter u_burst_cnt (
    .clk (clk_in),
    .rst (reset),
    .clr (burst_clr),
    .inc (burst_inc),
    .cnt (burst_cnt)
  );

  arb_sat_counter u_wait_cnt (
    .clk (clk_in),
    .rst (reset),
    .clr (wait_clr),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

  assign starved       = (wait_cnt >= STARVE_THR);
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.dma_rdata = bus.ram_rdata;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.dma_gnt   = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.ram_ena   = 1'b0;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    burst_clr     = 1'b1;
    burst_inc     = 1'b0;
    wait_clr      = 1'b1;
    wait_inc      = 1'b0;

    case (state)
      ARB_IDLE: begin
        bus.ram_ena = bus.cpu_req & bus.cpu_we;
        wait_clr    = ~bus.dma_req;
        wait_inc    = bus.dma_req;
        // The CPU keeps priority until the DMA has waited long enough.
        if (bus.dma_req && (!bus.cpu_req || starved)) begin
          state_nxt = ARB_DMA;
          wait_clr  = 1'b1;
        end
      end

      ARB_DMA: begin
        bus.dma_gnt   = 1'b1;
        bus.cpu_stall = bus.cpu_req;
        bus.ram_addr  = bus.dma_addr;
        bus.ram_wdata = bus.dma_wdata;
        bus.ram_ena   = bus.dma_req & bus.dma_we;
        burst_clr     = 1'b0;
        burst_inc     = bus.dma_req;
        if (!bus.dma_req || bus.dma_last || (burst_cnt == BURST_LAST)) begin
          state_nxt = ARB_IDLE;
        end
      end

      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase

    // While reset is held nothing may reach the RAM and the CPU must wait.
    if (reset) begin
      bus.dma_gnt   = 1'b0;
      bus.ram_ena   = 1'b0;
      bus.cpu_stall = bus.cpu_req;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level ownership/memory model
// predicts each cycle's outputs, and a monitor compares them off the edge.
module tb_dmem_arbiter;

  localparam int MAX_BURST    = 4;
  localparam int STARVE_LIMIT = 16;

  typedef struct {
    int          cyc;
    logic        gnt;
    logic        stall;
    logic        ena;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          cpu_rd;
    bit          dma_rd;
    logic [31:0] rd;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset;

  always #5 clk_in = ~clk_in;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  logic [31:0] ram     [64] = '{default: '0};
  logic [31:0] exp_mem [64] = '{default: '0};

  always @(posedge clk_in) begin
    if (bus.ram_ena) ram[bus.ram_addr[7:2]] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = ram[bus.ram_addr[7:2]];

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: who owns the memory, how long the DMA has waited,
  // and how many beats the current grant has used.
  bit m_owns = 1'b0;
  int m_wait = 0;
  int m_beats = 0;

  task automatic check_output(input string name, input int c,
                              input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit cr, input bit cw,
                                input logic [31:0] ca, input logic [31:0] cd,
                                input bit dr, input bit dw,
                                input logic [31:0] da, input logic [31:0] dd,
                                input bit dl);
    exp_t e;
    @(negedge clk_in);
    reset         = r;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dma_req   = dr;
    bus.dma_we    = dw;
    bus.dma_addr  = da;
    bus.dma_wdata = dd;
    bus.dma_last  = dl;
    cyc++;
    e.cyc    = cyc;
    e.cpu_rd = 1'b0;
    e.dma_rd = 1'b0;
    e.rd     = '0;
    if (r) begin
      e.gnt = 1'b0; e.ena = 1'b0; e.stall = cr;
      e.addr = ca;  e.wdata = cd;
      m_owns = 1'b0; m_wait = 0; m_beats = 0;
    end else if (!m_owns) begin
      e.gnt = 1'b0; e.stall = 1'b0; e.ena = cr & cw;
      e.addr = ca;  e.wdata = cd;
      if (cr && !cw) begin e.cpu_rd = 1'b1; e.rd = exp_mem[ca[7:2]]; end
      if (cr && cw) exp_mem[ca[7:2]] = cd;
      if (dr && (!cr || m_wait >= STARVE_LIMIT - 1)) begin
        m_owns = 1'b1; m_wait = 0; m_beats = 0;
      end else begin
        m_wait = dr ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      end
    end else begin
      e.gnt = 1'b1; e.stall = cr; e.ena = dr & dw;
      e.addr = da;  e.wdata = dd;
      if (dr) begin
        m_beats++;
        if (dw) exp_mem[da[7:2]] = dd;
        else begin e.dma_rd = 1'b1; e.rd = exp_mem[da[7:2]]; end
      end
      // A grant never exceeds MAX_BURST beats.
      if (!dr || dl || m_beats >= MAX_BURST) m_owns = 1'b0;
    end
    sb.push_back(e);
  endtask

  // DMA writes n beats from base; with cr set the CPU reads 0x40 while served
  // and tries to write 0x55 to 0x44 whenever it is stalled.
  task automatic run_dma(input logic [31:0] base, input logic [31:0] d0,
                         input int n, input bit use_last, input bit cr,
                         input int rst_beat);
    int          done = 0;
    bit          beat;
    bit          was_reset = 1'b0;
    logic [31:0] a = base;
    for (int i = 0; i < 300 && done < n && !was_reset; i++) begin
      beat = m_owns;
      if (beat && done == rst_beat) begin
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
                       1'b1, 1'b1, a, d0 + (a - base), 1'b0);
        was_reset = 1'b1;
      end else begin
        apply_stimulus(1'b0, cr, cr & beat, beat ? 32'h44 : 32'h40, 32'h55,
                       1'b1, 1'b1, a, d0 + (a - base), use_last && done == n - 1);
        if (beat) begin a += 4; done++; end
      end
    end
    total++;
    if (!was_reset && done < n) begin
      bad++;
      $display("[TB] FAIL dma_progress got=%0d want=%0d", done, n);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic cpu_read(input logic [31:0] a);
    apply_stimulus(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_output("dma_gnt",   mon_e.cyc, {31'b0, bus.dma_gnt},   {31'b0, mon_e.gnt});
        check_output("cpu_stall", mon_e.cyc, {31'b0, bus.cpu_stall}, {31'b0, mon_e.stall});
        check_output("ram_ena",   mon_e.cyc, {31'b0, bus.ram_ena},   {31'b0, mon_e.ena});
        check_output("ram_addr",  mon_e.cyc, bus.ram_addr,  mon_e.addr);
        check_output("ram_wdata", mon_e.cyc, bus.ram_wdata, mon_e.wdata);
        if (mon_e.cpu_rd) check_output("cpu_rdata", mon_e.cyc, bus.cpu_rdata, mon_e.rd);
        if (mon_e.dma_rd) check_output("dma_rdata", mon_e.cyc, bus.dma_rdata, mon_e.rd);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          dr = 1'b0;
    bit          cr, cw, dw, dl, rr;
    logic [31:0] ca, da;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_last = 1'b0;

    // Reset with both requesters active: no grant, no write, CPU stalled.
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h99,
                              1'b1, 1'b1, 32'h8, 32'h77, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cpu_read(32'h10);

    run_dma(32'h00, 32'hA000_0000, 3, 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) cpu_read(32'(i * 4));

    run_dma(32'hA0, 32'hB000_0000, 10, 1'b0, 1'b1, -1);
    cpu_read(32'h44);

    run_dma(32'h80, 32'hC000_0000, 5, 1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) cpu_read(32'h80 + 32'(i * 4));

    run_dma(32'h20, 32'h12345678, 1, 1'b1, 1'b0, -1);
    cpu_read(32'h20);

    for (int i = 0; i < 1000; i++) begin
      cr = ($urandom_range(0, 3) != 0);
      cw = ($urandom_range(0, 1) == 1);
      dw = ($urandom_range(0, 1) == 1);
      ca = 32'($urandom_range(0, 63)) << 2;
      da = 32'($urandom_range(0, 63)) << 2;
      if (dr) dr = ($urandom_range(0, 9) != 0);
      else    dr = ($urandom_range(0, 6) == 0);
      dl = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 199) == 0);
      apply_stimulus(rr, cr, cw, ca, $urandom, dr, dw, da, $urandom, dl);
    end

    repeat (3) @(negedge clk_in);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the CPU load/store port and a DMA/loader port used for memory init and debug dumps.
- CPU accesses go through with zero added latency whenever the DMA does not own the memory.
- DMA gets registered grants, bounded bursts and a starvation guard.
- Sits between the CPU, a DMA engine and the DMEM instance in the top-level dataflow module.

Parameters:
ADDR_W, 32, byte address width of both ports and of the RAM port
DATA_W, 32, data width
MAX_BURST, 8, max consecutive DMA beats per grant (range 1..255)
STARVE_LIMIT, 16, cycles a DMA request may wait before it preempts the CPU (range 1..255)

Ports:
clk_in  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU memory access this cycle
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data (combinational from ram_rdata)
cpu_stall  out  1  CPU must hold its PC and request; access not performed
dma_req  in  1  DMA wants a beat
dma_we  in  1  DMA write / read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_last  in  1  current DMA beat is the last of its burst
dma_gnt  out  1  DMA owns memory; beat performed when dma_gnt & dma_req
dma_rdata  out  DATA_W  DMA read data (combinational from ram_rdata)
ram_ena  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data (asynchronous read)

Behaviour:
- RAM model: asynchronous read, write on the rising clk_in edge when ram_ena=1.
- States: IDLE, DMA_OWN.
  - Registers: state, burst_cnt (8 bit), wait_cnt (8 bit).
- Reset, asynchronous: state=IDLE, burst_cnt=0, wait_cnt=0.
  - Outputs during reset: dma_gnt=0, ram_ena=0, cpu_stall=cpu_req.
- IDLE:
  - CPU mux selected. ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_ena=cpu_req&cpu_we, cpu_stall=0.
  - With cpu_req=0, ram_addr/ram_wdata still follow the CPU port and ram_ena=0.
  - wait_cnt increments (saturating) while dma_req=1; it clears when dma_req=0.
  - Go to DMA_OWN next edge if dma_req & (!cpu_req | wait_cnt>=STARVE_LIMIT-1). Clear wait_cnt and burst_cnt on the transition.
  - Simultaneous requests below the limit: CPU wins.
- DMA_OWN:
  - dma_gnt=1. DMA mux selected. ram_ena=dma_req&dma_we.
  - cpu_stall=cpu_req. The CPU write is suppressed.
  - Each beat (dma_req=1) increments burst_cnt.
  - Return to IDLE next edge if any of: dma_req=0; a beat with dma_last=1; a beat with burst_cnt==MAX_BURST-1.
  - A new DMA grant then requires re-arbitration from IDLE. With cpu_req pending, the CPU wins unless the starvation guard has fired again.
- Latency:
  - CPU: 0 cycles when not stalled.
  - DMA: first beat at the earliest 1 cycle after dma_req rises.
  - Read data is valid in the same cycle as the beat.
- Reset mid-burst: the burst is aborted immediately. No partial write after reset deasserts; the DMA must re-request.
- dma_rdata and cpu_rdata both always drive ram_rdata. Consumers qualify them by gnt/stall.
- Address/data are passed through unmodified. Base-offset subtraction stays outside this block.

Decomposition:
- The shared defines header gets the bus width macros (memory address/data buses) and the state encodings ARB_IDLE=1'b0, ARB_DMA=1'b1.
- One natural sub-module: arb_sat_counter, an 8-bit saturating counter with clear/inc. It is instantiated for burst_cnt and wait_cnt.
- The muxes stay inline.

Test Plan:
- CPU-only: cpu_req=1, cpu_we=1, addr=0x10, data=0xDEADBEEF, then read 0x10 → ram_ena=1 for 1 cycle, cpu_stall=0 throughout, read returns 0xDEADBEEF.
- DMA burst, CPU idle: dma_req held, writes to 0x00..0x1C, dma_last on beat 8 → dma_gnt rises 1 cycle after req, exactly 8 writes, state IDLE after beat 8.
- Burst cap: MAX_BURST=4, dma_req held for 10 beats with cpu_req=1 → 4 DMA beats, then the CPU gets ≥1 cycle with cpu_stall=0 before the next DMA grant.
- Contention: cpu_req and dma_req both held continuously, STARVE_LIMIT=16 → CPU served 16 cycles, then dma_gnt=1 and cpu_stall=1 during the DMA burst. A CPU write of 0x55 during the stall is never written.
- Reset mid-burst: assert reset asynchronously (between edges) on DMA beat 3 → dma_gnt=0 and ram_ena=0 immediately. Post-reset state is IDLE, and memory holds only beats 1-2.
- Read path: preload 0x20=0x12345678 via DMA, then CPU read 0x20 → cpu_rdata=0x12345678 in the same cycle, cpu_stall=0.
